jtag_tap_param: RTL and testbench
=================================

JTAG_TAP_PARAM -- requirements
Module: jtag_tap_param

Interface
REQ-001 Parameter IR_W, default 2, instruction register width (>=2).
REQ-002 Parameter N_IN, default 36, boundary cells on core inputs.
REQ-003 Parameter N_OUT, default 0, boundary cells on core outputs (0 allowed).
REQ-004 Parameter IDCODE_VAL, default 32'h0000_0001, device ID (bit0 SHALL be 1).
REQ-005 Port TCLK  in  1  sole clock, scan clock.
REQ-006 Port TRST  in  1  reset, asynchronous, active-low.
REQ-007 Port TMS  in  1  mode select; TDI  in  1  serial data in.
REQ-008 Port TDO  out  1  serial data out; tdo_en  out  1  high while Shift-IR/Shift-DR.
REQ-009 Port pi  in  N_IN  pad inputs; ci  out  N_IN  to core inputs.
REQ-010 Port co  in  N_OUT  core outputs; po  out  N_OUT  to pads.
REQ-011 Port tap_state  out  4  current TAP state code; ir  out  IR_W  active instruction.

Function
REQ-012 16-state TAP FSM, transitions per IEEE 1149.1 on TMS at TCLK rise; codes: TLR=F RTI=C SelDR=7 CapDR=6 ShDR=2 Ex1DR=1 PauseDR=3 Ex2DR=0 UpdDR=5 SelIR=4 CapIR=E ShIR=A Ex1IR=9 PauseIR=B Ex2IR=8 UpdIR=D.
REQ-013 TMS=1 for 5 consecutive rises SHALL reach TLR from any state.
REQ-014 Opcodes: EXTEST=0, SAMPLE=1, IDCODE=2, BYPASS=all ones; any other code SHALL act as BYPASS.
REQ-015 IR shift reg: CapIR loads {0..0,2'b01}; ShIR shifts right, TDI into MSB, TDO=bit0.
REQ-016 Active IR SHALL load from IR shift reg only at rise in UpdIR; in TLR it SHALL be IDCODE.
REQ-017 DR selected by active IR: BYPASS -> 1-bit reg, captures 0; IDCODE -> 32-bit reg, captures IDCODE_VAL; EXTEST/SAMPLE -> BSR.
REQ-018 BSR length N_IN+N_OUT; bits [N_IN-1:0] input cells, [N_IN+N_OUT-1:N_IN] output cells; CapDR loads {co,pi}.
REQ-019 ShDR: selected DR shifts right, TDI into MSB, TDO=bit0, one bit per rise; Pause/Exit states hold contents.
REQ-020 BSR update latch SHALL load from BSR at rise in UpdDR only; shift activity never alters it.
REQ-021 ir=EXTEST: ci=update[N_IN-1:0], po=update[N_IN+N_OUT-1:N_IN]; otherwise ci=pi, po=co (combinational).
REQ-022 TDO SHALL be registered on TCLK fall from bit0 of the shifting register; 0 when tdo_en=0.
REQ-023 DR shift length per instruction: BYPASS 1, IDCODE 32, BSR N_IN+N_OUT; IDCODE shifted LSB first.
REQ-024 N_OUT=0: co/po SHALL be unused/absent-safe; BSR length N_IN.
REQ-025 IR changes SHALL take effect on ci/po the cycle after UpdIR rise.

Reset
REQ-026 TRST=0 SHALL asynchronously force: tap_state=F, ir=IDCODE, IR/DR shift regs 0, BSR update latch 0, TDO=0, tdo_en=0.
REQ-027 Reset mid-shift SHALL discard partial IR/DR contents; update latch unchanged only by prior UpdDR, then cleared.
REQ-028 Entry into TLR via TMS (TRST high) SHALL set ir=IDCODE and clear update latch; FSM then sits in TLR until TMS=0.

Verification
REQ-029 TRST low 2 cycles in ShDR -> tap_state=F, ir=2, tdo_en=0, ci=pi immediately.
REQ-030 From any state TMS=1 x5 -> tap_state=F; then TMS=0 -> C.
REQ-031 Reset, TMS 0,1,0,0 -> ShDR; 32 shifts -> TDO yields IDCODE_VAL LSB first, first bit 1.
REQ-032 IR shift 2'b11 (BYPASS) -> CapIR TDO bits 1,0; in ShDR TDO = TDI delayed one cycle, first bit 0.
REQ-033 IR=0 (EXTEST), shift 36'h0deadbeef LSB first, UpdDR -> ci=36'h0deadbeef; pi toggles do not change ci.
REQ-034 IR=1 (SAMPLE), pi=36'h123456789, CapDR then 36 shifts -> TDO stream = 36'h123456789 LSB first; ci tracks pi throughout.

Source files
------------

// File: rtl/jtag_tap_param.sv
// IEEE 1149.1 style TAP controller with parameterised IR width and boundary-scan chain.
// State table (code | meaning): F TLR, C RTI, 7 SelDR, 6 CapDR, 2 ShDR, 1 Ex1DR, 3 PauseDR, 0 Ex2DR,
// 5 UpdDR, 4 SelIR, E CapIR, A ShIR, 9 Ex1IR, B PauseIR, 8 Ex2IR, D UpdIR.
module jtag_tap_param #(
    parameter int          IR_W       = 2,
    parameter int          N_IN       = 36,
    parameter int          N_OUT      = 0,
    parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
    input  logic                                TCLK,
    input  logic                                TRST,
    input  logic                                TMS,
    input  logic                                TDI,
    output logic                                TDO,
    output logic                                tdo_en,
    input  logic [N_IN-1:0]                     pi,
    output logic [N_IN-1:0]                     ci,
    input  logic [((N_OUT > 0) ? N_OUT : 1)-1:0] co,
    output logic [((N_OUT > 0) ? N_OUT : 1)-1:0] po,
    output logic [3:0]                          tap_state,
    output logic [IR_W-1:0]                     ir
);

    localparam int BSR_W = N_IN + N_OUT;

    localparam logic [IR_W-1:0] OP_EXTEST = '0;
    localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(1);
    localparam logic [IR_W-1:0] OP_IDCODE = IR_W'(2);

    typedef enum logic [3:0] {
        S_TLR    = 4'hF, S_RTI    = 4'hC, S_SELDR  = 4'h7, S_CAPDR  = 4'h6,
        S_SHDR   = 4'h2, S_EX1DR  = 4'h1, S_PAUSEDR = 4'h3, S_EX2DR = 4'h0,
        S_UPDDR  = 4'h5, S_SELIR  = 4'h4, S_CAPIR  = 4'hE, S_SHIR   = 4'hA,
        S_EX1IR  = 4'h9, S_PAUSEIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR  = 4'hD
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IR_W-1:0]   r_ir;
    logic [IR_W-1:0]   r_ir_sr;
    logic              r_bypass;
    logic [31:0]       r_id;
    logic [BSR_W-1:0]  r_bsr;
    logic [BSR_W-1:0]  r_upd;
    logic              r_tdo;
    logic              r_tdo_en;
    logic [BSR_W-1:0]  w_cap;
    logic              w_sel_bsr;
    logic              w_sel_id;
    logic              w_extest;
    logic              w_dr_bit0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_TLR:     w_next = TMS ? S_TLR   : S_RTI;
            S_RTI:     w_next = TMS ? S_SELDR : S_RTI;
            S_SELDR:   w_next = TMS ? S_SELIR : S_CAPDR;
            S_CAPDR:   w_next = TMS ? S_EX1DR : S_SHDR;
            S_SHDR:    w_next = TMS ? S_EX1DR : S_SHDR;
            S_EX1DR:   w_next = TMS ? S_UPDDR : S_PAUSEDR;
            S_PAUSEDR: w_next = TMS ? S_EX2DR : S_PAUSEDR;
            S_EX2DR:   w_next = TMS ? S_UPDDR : S_SHDR;
            S_UPDDR:   w_next = TMS ? S_SELDR : S_RTI;
            S_SELIR:   w_next = TMS ? S_TLR   : S_CAPIR;
            S_CAPIR:   w_next = TMS ? S_EX1IR : S_SHIR;
            S_SHIR:    w_next = TMS ? S_EX1IR : S_SHIR;
            S_EX1IR:   w_next = TMS ? S_UPDIR : S_PAUSEIR;
            S_PAUSEIR: w_next = TMS ? S_EX2IR : S_PAUSEIR;
            S_EX2IR:   w_next = TMS ? S_UPDIR : S_SHIR;
            S_UPDIR:   w_next = TMS ? S_SELDR : S_RTI;
            default:   w_next = S_TLR;
        endcase
    end

    // Unknown opcodes fall through to the bypass register.
    assign w_sel_bsr = (r_ir == OP_EXTEST) || (r_ir == OP_SAMPLE);
    assign w_sel_id  = (r_ir == OP_IDCODE);
    assign w_extest  = (r_ir == OP_EXTEST);
    assign w_dr_bit0 = w_sel_bsr ? r_bsr[0] : (w_sel_id ? r_id[0] : r_bypass);

    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            r_state  <= S_TLR;
            r_ir     <= OP_IDCODE;
            r_ir_sr  <= '0;
            r_bypass <= 1'b0;
            r_id     <= '0;
            r_bsr    <= '0;
            r_upd    <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == S_CAPIR)
                r_ir_sr <= IR_W'(1);
            else if (r_state == S_SHIR)
                r_ir_sr <= {TDI, r_ir_sr[IR_W-1:1]};

            if (r_state == S_CAPDR) begin
                if (w_sel_bsr)     r_bsr    <= w_cap;
                else if (w_sel_id) r_id     <= IDCODE_VAL;
                else               r_bypass <= 1'b0;
            end else if (r_state == S_SHDR) begin
                if (w_sel_bsr)     r_bsr    <= {TDI, r_bsr[BSR_W-1:1]};
                else if (w_sel_id) r_id     <= {TDI, r_id[31:1]};
                else               r_bypass <= TDI;
            end

            // Entering or holding TLR forces IDCODE and drops any applied pattern.
            if (w_next == S_TLR) begin
                r_ir  <= OP_IDCODE;
                r_upd <= '0;
            end else begin
                if (r_state == S_UPDIR)
                    r_ir <= r_ir_sr;
                if (r_state == S_UPDDR && w_sel_bsr)
                    r_upd <= r_bsr;
            end
        end
    end

    always_ff @(negedge TCLK or negedge TRST) begin
        if (!TRST) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo_en <= (r_state == S_SHIR) || (r_state == S_SHDR);
            if (r_state == S_SHIR)
                r_tdo <= r_ir_sr[0];
            else if (r_state == S_SHDR)
                r_tdo <= w_dr_bit0;
            else
                r_tdo <= 1'b0;
        end
    end

    assign TDO       = r_tdo;
    assign tdo_en    = r_tdo_en;
    assign tap_state = r_state;
    assign ir        = r_ir;
    assign ci        = w_extest ? r_upd[N_IN-1:0] : pi;

    generate
        if (N_OUT > 0) begin : g_out_cells
            assign w_cap = {co, pi};
            assign po    = w_extest ? r_upd[BSR_W-1:N_IN] : co;
        end else begin : g_no_out_cells
            logic w_unused_co;
            assign w_unused_co = ^co;
            assign w_cap       = pi;
            assign po          = '0;
        end
    endgenerate

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed bench for jtag_tap_param: table-driven FSM walk plus hand sequences
// for IDCODE, BYPASS, EXTEST, SAMPLE, TRST and TMS-reset behaviour.
module tb_jtag_tap_param;

    localparam logic [31:0] IDV = 32'hA5C3_0F17;

    logic        TCLK = 1'b0;
    logic        TRST;
    logic        TMS;
    logic        TDI;
    logic        TDO;
    logic        tdo_en;
    logic [35:0] pi;
    logic [35:0] ci;
    logic [0:0]  co;
    logic [0:0]  po;
    logic [3:0]  tap_state;
    logic [1:0]  ir;

    int n_checks = 0;
    int n_fail   = 0;

    jtag_tap_param #(.IR_W(2), .N_IN(36), .N_OUT(0), .IDCODE_VAL(IDV)) dut (
        .TCLK(TCLK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
        .pi(pi), .ci(ci), .co(co), .po(po), .tap_state(tap_state), .ir(ir)
    );

    always #5 TCLK = ~TCLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       tms;
        logic       tdi;
        logic [3:0] st;
        logic [1:0] ir;
        logic       en;
        logic       tdo;
    } vec_t;

    typedef struct packed {
        int         len;
        logic [7:0] bits;
        logic [3:0] st;
    } path_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCLK);
        @(negedge TCLK);
        #1;
    endtask

    task automatic load_ir(input logic [1:0] op);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, op[0]);
        tick(1'b1, op[1]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic goto_shdr();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic exit_shdr();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    vec_t        vecs [26];
    path_t       paths[6];
    logic [31:0] got_id;
    logic [35:0] got_bsr;
    logic [35:0] dpat;
    logic [7:0]  bpat;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 4'hC, 2'd2, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'h7, 2'd2, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'h6, 2'd2, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'h2, 2'd2, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 4'h1, 2'd2, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'h3, 2'd2, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'h0, 2'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'h2, 2'd2, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 4'h1, 2'd2, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'h5, 2'd2, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'h7, 2'd2, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 4'h4, 2'd2, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'hE, 2'd2, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'hA, 2'd2, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 4'h9, 2'd2, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'hB, 2'd2, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 4'h8, 2'd2, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 4'hA, 2'd2, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 4'h9, 2'd2, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 4'hD, 2'd2, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 4'hC, 2'd3, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 4'h7, 2'd3, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 1'b0, 4'h4, 2'd3, 1'b0, 1'b0};
        vecs[23] = '{1'b1, 1'b0, 4'hF, 2'd2, 1'b0, 1'b0};
        vecs[24] = '{1'b1, 1'b0, 4'hF, 2'd2, 1'b0, 1'b0};
        vecs[25] = '{1'b0, 1'b0, 4'hC, 2'd2, 1'b0, 1'b0};

        // TMS paths from RTI, applied LSB first
        paths[0] = '{3, 8'b0000_0001, 4'h2};
        paths[1] = '{4, 8'b0000_0011, 4'hA};
        paths[2] = '{4, 8'b0000_0101, 4'h3};
        paths[3] = '{5, 8'b0000_1011, 4'hB};
        paths[4] = '{4, 8'b0000_1101, 4'h5};
        paths[5] = '{6, 8'b0010_1011, 4'h8};

        TRST = 1'b0;
        TMS  = 1'b1;
        TDI  = 1'b0;
        co   = 1'b0;
        pi   = 36'h0_1357_9BDF;
        repeat (2) @(negedge TCLK);
        #1;
        check("rst_state", 64'(tap_state), 64'(4'hF));
        check("rst_ir", 64'(ir), 64'(2'd2));
        check("rst_tdo", 64'(TDO), 64'(1'b0));
        check("rst_tdo_en", 64'(tdo_en), 64'(1'b0));
        check("rst_ci", 64'(ci), 64'(pi));
        TRST = 1'b1;

        for (int i = 0; i < 26; i++) begin
            tick(vecs[i].tms, vecs[i].tdi);
            check($sformatf("vec%0d_state", i), 64'(tap_state), 64'(vecs[i].st));
            check($sformatf("vec%0d_ir", i), 64'(ir), 64'(vecs[i].ir));
            check($sformatf("vec%0d_tdo_en", i), 64'(tdo_en), 64'(vecs[i].en));
            check($sformatf("vec%0d_tdo", i), 64'(TDO), 64'(vecs[i].tdo));
        end

        // IDCODE read-out, LSB first
        goto_shdr();
        got_id[0] = TDO;
        check("idcode_first_bit", 64'(TDO), 64'(1'b1));
        for (int i = 1; i < 32; i++) begin
            tick(1'b0, 1'b0);
            got_id[i] = TDO;
        end
        exit_shdr();
        check("idcode_stream", 64'(got_id), 64'(IDV));

        // BYPASS via IR scan, IR capture pattern visible on TDO
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("capir_bit0", 64'(TDO), 64'(1'b1));
        tick(1'b0, 1'b1);
        check("capir_bit1", 64'(TDO), 64'(1'b0));
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("bypass_ir", 64'(ir), 64'(2'd3));
        goto_shdr();
        check("bypass_first", 64'(TDO), 64'(1'b0));
        bpat = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, bpat[i]);
            check($sformatf("bypass_bit%0d", i), 64'(TDO), 64'(bpat[i]));
        end
        exit_shdr();

        // EXTEST: shift a pattern and apply it
        pi = 36'hF_0F0F_0F0F;
        load_ir(2'd0);
        check("extest_ir", 64'(ir), 64'(2'd0));
        check("extest_ci_pre", 64'(ci), 64'(36'h0));
        goto_shdr();
        dpat = 36'h0_DEAD_BEEF;
        for (int i = 0; i < 36; i++) tick(i == 35, dpat[i]);
        check("extest_ci_after_shift", 64'(ci), 64'(36'h0));
        tick(1'b1, 1'b0);
        check("extest_ci_in_upddr", 64'(ci), 64'(36'h0));
        tick(1'b0, 1'b0);
        check("extest_ci_applied", 64'(ci), 64'(dpat));
        pi = 36'h5_A5A5_A5A5;
        #1;
        check("extest_ci_pi_toggle", 64'(ci), 64'(dpat));

        // TRST in the middle of a DR shift
        goto_shdr();
        tick(1'b0, 1'b1);
        TRST = 1'b0;
        #1;
        check("trst_state", 64'(tap_state), 64'(4'hF));
        check("trst_ir", 64'(ir), 64'(2'd2));
        check("trst_tdo_en", 64'(tdo_en), 64'(1'b0));
        check("trst_tdo", 64'(TDO), 64'(1'b0));
        check("trst_ci", 64'(ci), 64'(pi));
        repeat (2) @(posedge TCLK);
        @(negedge TCLK);
        #1;
        check("trst_hold_state", 64'(tap_state), 64'(4'hF));
        TRST = 1'b1;
        tick(1'b0, 1'b0);
        load_ir(2'd0);
        check("trst_latch_cleared", 64'(ci), 64'(36'h0));

        // SAMPLE: capture pi, stream it out while pi keeps moving
        pi = 36'h1_2345_6789;
        load_ir(2'd1);
        check("sample_ir", 64'(ir), 64'(2'd1));
        check("sample_ci_pre", 64'(ci), 64'(pi));
        goto_shdr();
        got_bsr[0] = TDO;
        for (int i = 1; i < 36; i++) begin
            pi = {pi[34:0], pi[35]};
            tick(1'b0, 1'b0);
            got_bsr[i] = TDO;
            check($sformatf("sample_ci_track%0d", i), 64'(ci), 64'(pi));
        end
        exit_shdr();
        check("sample_stream", 64'(got_bsr), 64'(36'h1_2345_6789));

        // TMS-driven TLR entry clears IR and update latch
        pi = 36'h0_0000_1111;
        load_ir(2'd0);
        goto_shdr();
        dpat = 36'h3_0000_00FF;
        for (int i = 0; i < 36; i++) tick(i == 35, dpat[i]);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("extest2_ci", 64'(ci), 64'(dpat));
        goto_shdr();
        repeat (5) tick(1'b1, 1'b0);
        check("tms_tlr_state", 64'(tap_state), 64'(4'hF));
        check("tms_tlr_ir", 64'(ir), 64'(2'd2));
        check("tms_tlr_ci", 64'(ci), 64'(pi));
        tick(1'b0, 1'b0);
        check("tms_tlr_exit", 64'(tap_state), 64'(4'hC));
        load_ir(2'd0);
        check("tms_tlr_latch_cleared", 64'(ci), 64'(36'h0));

        // Five TMS=1 from assorted states
        for (int p = 0; p < 6; p++) begin
            for (int b = 0; b < paths[p].len; b++) tick(paths[p].bits[b], 1'b0);
            check($sformatf("path%0d_state", p), 64'(tap_state), 64'(paths[p].st));
            repeat (5) tick(1'b1, 1'b0);
            check($sformatf("path%0d_tlr", p), 64'(tap_state), 64'(4'hF));
            tick(1'b0, 1'b0);
            check($sformatf("path%0d_rti", p), 64'(tap_state), 64'(4'hC));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
